// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into 32-bit imem writes.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned MEM_SIZE       = 4096,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_TAIL = ST_CSUM;
`else
    localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

    logic [2:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        code_q, code_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              accept;
    logic [31:0]       full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        sum_next;
`endif

    assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      || (state_q == ST_CSUM)
`endif
                      ;
    assign accept   = in_ready && in_valid;
    // Bytes shift in from the top, so the 4th byte completes a little-endian word.
    assign full     = {in_data, buf_q};
    assign cnt_inc  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign sum_next = sum_q + in_data;
`endif

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        code_d    = code_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif

        if (in_ready) begin
            if (accept) begin
                tmo_d  = '0;
                lane_d = lane_q + 2'd1;
                buf_d  = full[31:8];
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d  = sum_next;
`endif
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ERR;
                code_d  = 2'd2;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                    lane_d  = 2'd0;
                    tmo_d   = '0;
                    cnt_d   = '0;
                    code_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            ST_LEN: begin
                if (accept && lane_q == 2'd3) begin
                    if (full > MEM_SIZE) begin
                        state_d = ST_ERR;
                        code_d  = 2'd1;
                    end else begin
                        n_d     = full[ADDR_W:0];
                        state_d = (full == '0) ? ST_TAIL : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && lane_q == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = full;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d = ST_TAIL;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (sum_next == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        code_d  = 2'd3;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lane_q    <= 2'd0;
            buf_q     <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            code_q    <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign cpu_hold      = (state_q != ST_DONE);
    assign err_code      = code_q;
    assign words_written = cnt_q;
endmodule
